// File: rtl/bus_timer_slave_pkg.sv
// Shared definitions for the bus timer slave: bus polarities, bus widths,
// register map, CTRL bit positions and handshake state encoding.
package bus_timer_slave_pkg;

  // Bus polarity values (active-low enable, read high).
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  // Bus widths.
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  // Register indices, decoded from addr[1:0].
  localparam logic [1:0] BUS_TIMER_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] BUS_TIMER_ADDR_INTR    = 2'd1;
  localparam logic [1:0] BUS_TIMER_ADDR_EXPR    = 2'd2;
  localparam logic [1:0] BUS_TIMER_ADDR_COUNTER = 2'd3;

  // CTRL bit positions.
  localparam int BUS_TIMER_CTRL_START    = 0;
  localparam int BUS_TIMER_CTRL_PERIODIC = 1;

  // Handshake state encoding.
  typedef enum logic [1:0] {
    BUS_TIMER_ST_IDLE = 2'd0,
    BUS_TIMER_ST_WAIT = 2'd1,
    BUS_TIMER_ST_ACK  = 2'd2
  } bus_timer_state_e;

  // Zero-extend a single status bit to a full data word.
  function automatic logic [WORD_DATA_W-1:0] bus_timer_zext1(input logic b);
    return {{(WORD_DATA_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/bus_timer_slave_handshake.sv
// Reusable bus slave handshake: accepts a strobe while idle, inserts
// WAIT_CYCLES wait states, then pulses rdy_ low for one cycle.
// o_addr/o_rw/o_wr_data present the live bus fields on the accept cycle and
// the latched fields afterwards, so the datapath sees one consistent access.
module bus_slave_handshake
  import bus_timer_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,  // legal range 0..15
  parameter int DATA_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs_,
  input  logic              i_as_,
  input  logic              i_rw,
  input  logic [1:0]        i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_accept,
  output logic              o_ack_next,
  output logic              o_rw,
  output logic [1:0]        o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rdy_
);

  localparam logic       LP_NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  bus_timer_state_e  r_state;
  logic [3:0]        r_wait_cnt;
  logic [1:0]        r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rdy_;
  logic              w_accept;
  logic              w_ack_next;

  assign w_accept   = (i_cs_ == ENABLE_) && (i_as_ == ENABLE_) && (r_state == BUS_TIMER_ST_IDLE);
  assign w_ack_next = (w_accept && LP_NO_WAIT) ||
                      ((r_state == BUS_TIMER_ST_WAIT) && (r_wait_cnt == 4'd0));

  assign o_accept   = w_accept;
  assign o_ack_next = w_ack_next;
  assign o_addr     = w_accept ? i_addr    : r_addr;
  assign o_rw       = w_accept ? i_rw      : r_rw;
  assign o_wr_data  = w_accept ? i_wr_data : r_wr_data;
  assign o_rdy_     = r_rdy_;

  // Accept/wait/ack state machine with registered rdy_ and latched access fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= BUS_TIMER_ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 2'd0;
      r_rw       <= READ;
      r_wr_data  <= '0;
      r_rdy_     <= DISABLE_;
    end else begin
      r_rdy_ <= w_ack_next ? ENABLE_ : DISABLE_;
      case (r_state)
        BUS_TIMER_ST_IDLE: begin
          if (w_accept) begin
            r_addr    <= i_addr;
            r_rw      <= i_rw;
            r_wr_data <= i_wr_data;
            if (LP_NO_WAIT) begin
              r_state <= BUS_TIMER_ST_ACK;
            end else begin
              r_state    <= BUS_TIMER_ST_WAIT;
              r_wait_cnt <= LP_WAIT_LOAD;
            end
          end
        end
        BUS_TIMER_ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= BUS_TIMER_ST_ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        BUS_TIMER_ST_ACK: r_state <= BUS_TIMER_ST_IDLE;
        default:          r_state <= BUS_TIMER_ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped interval timer slave: CTRL/INTR/EXPR/COUNTER registers,
// wait-stated bus handshake and an expiration interrupt.
// Optional feature macro: BUS_TIMER_IRQ_EN (INTR register and irq output);
// when undefined INTR reads 0, writes to it are dropped and irq stays 0.
module bus_timer_slave
  import bus_timer_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wrData,
  output logic [WORD_DATA_W-1:0] rdData,
  output logic                   rdy_,
  output logic                   irq
);

  logic                   w_accept;
  logic                   w_ack_next;
  logic                   w_rw;
  logic [1:0]             w_addr;
  logic [WORD_DATA_W-1:0] w_wr_data;
  logic                   w_unused_addr;
  logic                   w_wr_en;
  logic                   w_wr_ctrl;
  logic                   w_wr_expr;
  logic                   w_wr_cnt;
  logic                   w_cnt_ovr;
  logic                   w_expire;
  logic                   w_intr;
  logic [WORD_DATA_W-1:0] w_rd_mux;

  logic                   r_start;
  logic                   r_periodic;
  logic [WORD_DATA_W-1:0] r_expr;
  logic [WORD_DATA_W-1:0] r_counter;
  logic [WORD_DATA_W-1:0] r_rd_data;
  logic                   r_irq;

  // Only the low two address bits select a register.
  assign w_unused_addr = ^addr[WORD_ADDR_W-1:2];

  bus_slave_handshake #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .DATA_W      (WORD_DATA_W)
  ) u_handshake (
    .i_clk      (clk),
    .i_rst_n    (reset_),
    .i_cs_      (cs_),
    .i_as_      (as_),
    .i_rw       (rw),
    .i_addr     (addr[1:0]),
    .i_wr_data  (wrData),
    .o_accept   (w_accept),
    .o_ack_next (w_ack_next),
    .o_rw       (w_rw),
    .o_addr     (w_addr),
    .o_wr_data  (w_wr_data),
    .o_rdy_     (rdy_)
  );

  // Writes commit on the accept edge.
  assign w_wr_en   = w_accept && (w_rw == WRITE);
  assign w_wr_ctrl = w_wr_en && (w_addr == BUS_TIMER_ADDR_CTRL);
  assign w_wr_expr = w_wr_en && (w_addr == BUS_TIMER_ADDR_EXPR);
  assign w_wr_cnt  = w_wr_en && (w_addr == BUS_TIMER_ADDR_COUNTER);

  // A CTRL or COUNTER write replaces this cycle's counter update, expiration included.
  assign w_cnt_ovr = w_wr_ctrl || w_wr_cnt;
  assign w_expire  = r_start && (r_counter == r_expr) && !w_cnt_ovr;

  // CTRL and EXPR registers; one-shot mode drops start on expiration.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_start    <= 1'b0;
      r_periodic <= 1'b0;
      r_expr     <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_start    <= w_wr_data[BUS_TIMER_CTRL_START];
        r_periodic <= w_wr_data[BUS_TIMER_CTRL_PERIODIC];
      end else if (w_expire && !r_periodic) begin
        r_start <= 1'b0;
      end
      if (w_wr_expr) begin
        r_expr <= w_wr_data;
      end
    end
  end

  // Counter: bus write first, then hold on CTRL write, then expire/increment.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_counter <= '0;
    end else if (w_wr_cnt) begin
      r_counter <= w_wr_data;
    end else if (w_wr_ctrl) begin
      r_counter <= r_counter;
    end else if (w_expire) begin
      r_counter <= '0;
    end else if (r_start) begin
      r_counter <= r_counter + 32'd1;
    end
  end

`ifdef BUS_TIMER_IRQ_EN
  logic w_wr_intr;
  logic r_intr;

  assign w_wr_intr = w_wr_en && (w_addr == BUS_TIMER_ADDR_INTR);
  assign w_intr    = r_intr;

  // INTR status bit: expiration sets it and beats a simultaneous bus write.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_intr <= 1'b0;
    end else if (w_expire) begin
      r_intr <= 1'b1;
    end else if (w_wr_intr) begin
      r_intr <= w_wr_data[0];
    end
  end

  // irq is the INTR bit, re-registered.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_intr;
    end
  end
`else
  assign w_intr = 1'b0;

  // Interrupt disabled: irq held low.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= 1'b0;
    end
  end
`endif

  // Register read multiplexer.
  always_comb begin
    w_rd_mux = '0;
    case (w_addr)
      BUS_TIMER_ADDR_CTRL:    w_rd_mux = {{(WORD_DATA_W-2){1'b0}}, r_periodic, r_start};
      BUS_TIMER_ADDR_INTR:    w_rd_mux = bus_timer_zext1(w_intr);
      BUS_TIMER_ADDR_EXPR:    w_rd_mux = r_expr;
      BUS_TIMER_ADDR_COUNTER: w_rd_mux = r_counter;
      default:                w_rd_mux = '0;
    endcase
  end

  // Read data is captured on the edge entering ACK and is zero otherwise.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rd_data <= '0;
    end else if (w_ack_next && (w_rw == READ)) begin
      r_rd_data <= w_rd_mux;
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rdData = r_rd_data;
  assign irq    = r_irq;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: one instance with no wait states and
// one with three, driven on the falling edge and sampled on the falling edge.
module tb_bus_timer_slave;
  import bus_timer_slave_pkg::*;

`ifdef BUS_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_;
  logic        cs0_, cs3_, as_, rw;
  logic [29:0] addr;
  logic [31:0] wrData;
  logic [31:0] rd0, rd3;
  logic        rdy0_, rdy3_, irq0, irq3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_timer_slave #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_(reset_), .cs_(cs0_), .as_(as_), .rw(rw), .addr(addr),
    .wrData(wrData), .rdData(rd0), .rdy_(rdy0_), .irq(irq0));

  bus_timer_slave #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset_(reset_), .cs_(cs3_), .as_(as_), .rw(rw), .addr(addr),
    .wrData(wrData), .rdData(rd3), .rdy_(rdy3_), .irq(irq3));

  // One strobe cycle, then wait (bounded) for rdy_; lat = cycles after the strobe.
  task automatic access(input int which, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, output logic [31:0] rdv, output int lat);
    int k;
    @(negedge clk);
    if (which == 3) cs3_ = 1'b0; else cs0_ = 1'b0;
    as_ = 1'b0; rw = wr ? WRITE : READ; addr = {28'd0, a}; wrData = d;
    lat = -1; rdv = 32'd0; k = 0;
    while (lat < 0 && k < 20) begin
      k++;
      @(negedge clk);
      if (k == 1) begin cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1; rw = READ; end
      if (((which == 3) ? rdy3_ : rdy0_) == 1'b0) begin
        lat = k;
        rdv = (which == 3) ? rd3 : rd0;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v; int lat;
    reset_ = 1'b0; cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1; rw = READ; addr = '0; wrData = '0;
    repeat (3) @(negedge clk);
    checks++; if (rdy0_ !== 1'b1 || rdy3_ !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b/%b want 1/1", rdy0_, rdy3_); end
    checks++; if (rd0 !== 32'd0 || rd3 !== 32'd0) begin errors++; $display("FAIL reset_rddata: got %h/%h want 0", rd0, rd3); end
    checks++; if (irq0 !== 1'b0 || irq3 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b/%b want 0", irq0, irq3); end
    reset_ = 1'b1;
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (lat !== 1 || v !== 32'd0) begin errors++; $display("FAIL reset_counter: got lat %0d data %h want lat 1 data 0", lat, v); end
    access(0, 1'b0, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", v); end
  endtask

  task automatic test_expr_rw;
    logic [31:0] v; int lat;
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd5, v, lat);
    checks++; if (lat !== 1 || v !== 32'd0) begin errors++; $display("FAIL expr_write: got lat %0d data %h want lat 1 data 0", lat, v); end
    access(0, 1'b0, BUS_TIMER_ADDR_EXPR, 32'd0, v, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL expr_read_lat: got %0d want 1", lat); end
    checks++; if (v !== 32'h0000_0005) begin errors++; $display("FAIL expr_read_data: got %h want 00000005", v); end
    @(negedge clk);
    checks++; if (rdy0_ !== 1'b1 || rd0 !== 32'd0) begin errors++; $display("FAIL rdy_one_cycle: got rdy %b data %h want 1/0", rdy0_, rd0); end
  endtask

  task automatic test_wait_states;
    logic [31:0] v; int lat; int lows; logic [31:0] cap;
    access(3, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd100, v, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wait_write_lat: got %0d want 4", lat); end
    access(3, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd1, v, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wait_ctrl_lat: got %0d want 4", lat); end
    // Counter started on that accept edge; read it with a stray strobe during WAIT.
    @(negedge clk);
    cs3_ = 1'b0; as_ = 1'b0; rw = READ; addr = {28'd0, BUS_TIMER_ADDR_COUNTER};
    lows = 0; cap = 32'hFFFF_FFFF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin addr = {28'd0, BUS_TIMER_ADDR_EXPR}; end
      if (k == 2) begin cs3_ = 1'b1; as_ = 1'b1; end
      if (rdy3_ == 1'b0) begin
        lows++;
        if (k == 4) cap = rd3;
      end
    end
    checks++; if (lows !== 1) begin errors++; $display("FAIL wait_rdy_count: got %0d pulses want 1", lows); end
    checks++; if (cap !== 32'd7) begin errors++; $display("FAIL wait_counter_data: got %h want 00000007 at cycle 4", cap); end
  endtask

  task automatic test_oneshot;
    logic [31:0] v; int lat;
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd4, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd1, v, lat);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (irq0 !== ((k >= 7) ? IRQ_ON : 1'b0)) begin
        errors++; $display("FAIL oneshot_irq: cycle %0d got %b want %b", k, irq0, (k >= 7) ? IRQ_ON : 1'b0);
      end
    end
    access(0, 1'b0, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL oneshot_ctrl: got %h want 0", v); end
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL oneshot_counter: got %h want 0", v); end
    access(0, 1'b0, BUS_TIMER_ADDR_INTR, 32'd0, v, lat);
    checks++; if (v !== {31'd0, IRQ_ON}) begin errors++; $display("FAIL oneshot_intr: got %h want %h", v, {31'd0, IRQ_ON}); end
    access(0, 1'b1, BUS_TIMER_ADDR_INTR, 32'd0, v, lat);
    @(negedge clk);
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL intr_clear: got %b want 0", irq0); end
  endtask

  task automatic test_periodic;
    logic [31:0] v; int lat;
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd2, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd3, v, lat);
    repeat (4) @(negedge clk);
    checks++; if (irq0 !== IRQ_ON) begin errors++; $display("FAIL periodic_first_irq: got %b want %b", irq0, IRQ_ON); end
    // This write lands on the second expiring edge: the set must win.
    access(0, 1'b1, BUS_TIMER_ADDR_INTR, 32'd0, v, lat);
    @(negedge clk);
    checks++; if (irq0 !== IRQ_ON) begin errors++; $display("FAIL periodic_set_wins: got %b want %b", irq0, IRQ_ON); end
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL periodic_counter: got %h want 00000002", v); end
    access(0, 1'b0, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL periodic_ctrl: got %h want 00000003", v); end
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_INTR, 32'd0, v, lat);
  endtask

  task automatic test_wrap;
    logic [31:0] v; int lat;
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd5, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_COUNTER, 32'hFFFF_FFFE, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd3, v, lat);
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_top: got %h want ffffffff", v); end
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL wrap_after: got %h want 00000001", v); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL wrap_no_irq: got %b want 0", irq0); end
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    // EXPR = 0 with start set expires every cycle, pinning COUNTER at 0.
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd0, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    access(0, 1'b1, BUS_TIMER_ADDR_CTRL, 32'd1, v, lat);
    access(0, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL expr0_counter: got %h want 0", v); end
    access(0, 1'b0, BUS_TIMER_ADDR_CTRL, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL expr0_oneshot_ctrl: got %h want 0", v); end
    checks++; if (irq0 !== IRQ_ON) begin errors++; $display("FAIL expr0_irq: got %b want %b", irq0, IRQ_ON); end
    access(0, 1'b1, BUS_TIMER_ADDR_INTR, 32'd0, v, lat);
  endtask

  task automatic test_deassert;
    logic [31:0] v; int lat; int lows;
    access(0, 1'b1, BUS_TIMER_ADDR_EXPR, 32'd9, v, lat);
    @(negedge clk);
    cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b0; rw = WRITE;
    addr = {28'd0, BUS_TIMER_ADDR_EXPR}; wrData = 32'h0000_DEAD;
    lows = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rdy0_ == 1'b0 || rdy3_ == 1'b0) lows++;
    end
    as_ = 1'b1; rw = READ;
    checks++; if (lows !== 0) begin errors++; $display("FAIL deassert_rdy: got %0d pulses want 0", lows); end
    access(0, 1'b0, BUS_TIMER_ADDR_EXPR, 32'd0, v, lat);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL deassert_expr: got %h want 00000009", v); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] v; int lat; int lows;
    @(negedge clk);
    cs3_ = 1'b0; as_ = 1'b0; rw = READ; addr = {28'd0, BUS_TIMER_ADDR_COUNTER};
    @(negedge clk);
    cs3_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    checks++; if (rdy3_ !== 1'b1 || rd3 !== 32'd0 || irq3 !== 1'b0) begin
      errors++; $display("FAIL midwait_reset_outputs: got rdy %b data %h irq %b want 1/0/0", rdy3_, rd3, irq3);
    end
    @(negedge clk);
    reset_ = 1'b1;
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rdy3_ == 1'b0) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL midwait_stray_rdy: got %0d pulses want 0", lows); end
    access(3, 1'b0, BUS_TIMER_ADDR_COUNTER, 32'd0, v, lat);
    checks++; if (lat !== 4 || v !== 32'd0) begin errors++; $display("FAIL midwait_counter: got lat %0d data %h want lat 4 data 0", lat, v); end
    access(0, 1'b0, BUS_TIMER_ADDR_EXPR, 32'd0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL midwait_expr_reset: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_expr_rw();
    test_wait_states();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_deassert();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
